mem_access_ctrl: RTL and testbench

Sequencing controller between the EX/MEM pipeline register and the word-addressed data memory. It accepts one operation per valid/ready handshake: load, store, or non-memory pass-through. It drives the memory read/write strobes for a fixed number of wait cycles, then holds the result and writeback metadata on a valid/ready output toward the MEM/WB register. It also provides the stall source (`in_ready` low) for upstream stages.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_wait_counter.sv | 29 ++
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage controller.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT = 10;
  localparam int REG_IDX_W     = 5;
  localparam int CNT_W         = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that paces memory wait states; saturates at zero.
module mem_wait_counter
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between EX/MEM and the data memory: load/store/pass-through with wait states.
// Optional address bounds checking is enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_read,
  input  logic                 in_write,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_reg_write,
  output logic                 out_err
);

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic LP_BOUNDS_EN = 1'b1;
`else
  localparam logic LP_BOUNDS_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(WAIT_STATES - 1);

  state_t                r_state;
  logic                  r_is_load;
  logic                  r_is_store;
  logic                  r_err;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic [REG_IDX_W-1:0]  r_out_rd;
  logic                  r_out_reg_write;

  logic                  w_store;
  logic                  w_load;
  logic                  w_mem_op;
  logic                  w_oob;
  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_cnt_zero;

  // A store wins when both read and write are requested.
  assign w_store  = in_write;
  assign w_load   = in_read && !in_write;
  assign w_mem_op = w_store || w_load;
  assign w_oob    = LP_BOUNDS_EN && (in_addr >= ADDR_W'(DEPTH));
  assign w_accept = in_valid && (r_state == IDLE);

  mem_wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept && w_mem_op),
    .i_load_val (LP_CNT_INIT),
    .i_dec      (r_state == WAIT),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_is_load       <= 1'b0;
      r_is_store      <= 1'b0;
      r_err           <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_rd        <= '0;
      r_out_reg_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mem_addr  <= in_addr;
            r_mem_wdata <= in_wdata;
            r_out_rd    <= in_rd;
            r_is_load   <= w_load;
            r_is_store  <= w_store;
            r_err       <= w_mem_op && w_oob;
            if (w_mem_op) begin
              r_state         <= WAIT;
              r_out_data      <= '0;
              r_out_reg_write <= w_load && in_reg_write && !w_oob;
              r_mem_read      <= w_load && !w_oob;
              // The single write pulse lands in the WAIT cycle whose count is zero.
              r_mem_write     <= w_store && !w_oob && (LP_CNT_INIT == '0);
            end else begin
              r_state         <= RESP;
              r_out_data      <= in_wdata;
              r_out_reg_write <= in_reg_write;
              r_out_valid     <= 1'b1;
            end
          end
        end
        WAIT: begin
          r_mem_write <= r_is_store && !r_err && (w_cnt == CNT_W'(1));
          if (w_cnt_zero) begin
            r_state     <= RESP;
            r_mem_read  <= 1'b0;
            r_out_valid <= 1'b1;
            if (r_is_load && !r_err) begin
              r_out_data <= mem_rdata;
            end
          end
        end
        RESP: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_rd        = r_out_rd;
  assign out_reg_write = r_out_reg_write;
  assign out_err       = r_out_valid && r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table plus scoreboard, WAIT_STATES 1 and 3.
// Expectations follow MEM_BOUNDS_CHECK_EN when it is defined for the build.
module tb_mem_access_ctrl;

  localparam int WS1 = 1;
  localparam int WS3 = 3;

  typedef struct {
    logic        rdF;
    logic        wrF;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        regWrite;
    logic [31:0] expData;
    logic        expRegWrite;
    logic        expErr;
    int          expReads;
    int          expWrites;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, rstN3;
  logic        inValid, inRead, inWrite, inRegWrite, outReady;
  logic [31:0] inAddr, inWdata;
  logic [4:0]  inRd;

  logic        inReady, memRead, memWrite, outValid, outRegWrite, outErr;
  logic [31:0] memAddr, memWdata, memRdata, outData;
  logic [4:0]  outRd;

  logic        inReady3, memRead3, memWrite3, outValid3, outRegWrite3, outErr3;
  logic [31:0] memAddr3, memWdata3, outData3;
  logic [31:0] memRdata3 = 32'h1234_5678;
  logic [4:0]  outRd3;

  logic [31:0] model [0:15];
  int          readCount, writeCount, baseReads, baseWrites;
  int          compared = 0;
  int          mismatched = 0;
  vec_t        vecs [11];
  vec_t        sbQueue [$];

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(10), .WAIT_STATES(WS1)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
    .in_read(inRead), .in_write(inWrite), .in_addr(inAddr), .in_wdata(inWdata),
    .in_rd(inRd), .in_reg_write(inRegWrite), .mem_read(memRead), .mem_write(memWrite),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_rd(outRd),
    .out_reg_write(outRegWrite), .out_err(outErr)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(10), .WAIT_STATES(WS3)) dut3 (
    .clk(clk), .rst_n(rstN3), .in_valid(inValid), .in_ready(inReady3),
    .in_read(inRead), .in_write(inWrite), .in_addr(inAddr), .in_wdata(inWdata),
    .in_rd(inRd), .in_reg_write(inRegWrite), .mem_read(memRead3), .mem_write(memWrite3),
    .mem_addr(memAddr3), .mem_wdata(memWdata3), .mem_rdata(memRdata3),
    .out_valid(outValid3), .out_ready(outReady), .out_data(outData3), .out_rd(outRd3),
    .out_reg_write(outRegWrite3), .out_err(outErr3)
  );

  // Data memory model: combinational read, write on the edge ending the strobe cycle.
  assign memRdata = (memAddr < 32'd16) ? model[memAddr[3:0]] : 32'h0;

  always @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < 16; i++) model[i] <= 32'h1000 + i;
      model[1] <= 32'd122;
    end else if (memWrite && (memAddr < 32'd16)) begin
      model[memAddr[3:0]] <= memWdata;
    end
  end

  always @(negedge clk) begin
    if (!rstN) begin
      readCount  = 0;
      writeCount = 0;
    end else begin
      if (memRead)  readCount++;
      if (memWrite) writeCount++;
    end
  end

  function automatic vec_t mkVec(input logic r, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [4:0] rd, input logic rw,
                                 input logic [31:0] ed, input logic erw, input logic ee,
                                 input int er, input int ew);
    vec_t v;
    v.rdF = r; v.wrF = w; v.addr = a; v.wdata = d; v.rd = rd; v.regWrite = rw;
    v.expData = ed; v.expRegWrite = erw; v.expErr = ee; v.expReads = er; v.expWrites = ew;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int guard = 0;
    @(negedge clk);
    while (!inReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkVal("in_ready_before_accept", inReady, 1);
    inValid = 1'b1; inRead = v.rdF; inWrite = v.wrF; inAddr = v.addr;
    inWdata = v.wdata; inRd = v.rd; inRegWrite = v.regWrite;
    baseReads = readCount;
    baseWrites = writeCount;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    sbQueue.push_back(v);
  endtask

  task automatic checkOutput(input int holdCycles);
    vec_t e;
    int   lat = 0;
    while (!outValid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sbQueue.pop_front();
    checkVal("latency", lat, (e.rdF || e.wrF) ? WS1 : 0);
    checkVal("out_valid", outValid, 1);
    checkVal("out_data", outData, e.expData);
    checkVal("out_rd", outRd, e.rd);
    checkVal("out_reg_write", outRegWrite, e.expRegWrite);
    checkVal("out_err", outErr, e.expErr);
    checkVal("mem_addr_held", memAddr, e.addr);
    checkVal("read_cycles", readCount - baseReads, e.expReads);
    checkVal("write_pulses", writeCount - baseWrites, e.expWrites);
    checkVal("in_ready_in_resp", inReady, 0);
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
      checkVal("hold_valid", outValid, 1);
      checkVal("hold_data", outData, e.expData);
      checkVal("hold_rd", outRd, e.rd);
      checkVal("hold_in_ready", inReady, 0);
    end
    if (holdCycles > 0) begin
      @(negedge clk);
      outReady = 1'b1;
    end
    @(posedge clk);
    #1;
    checkVal("release_valid", outValid, 0);
    checkVal("release_in_ready", inReady, 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, rc;
    vecs[0] = mkVec(1, 0, 1, 0, 3, 1, 32'd122, 1, 0, 1, 0);
    vecs[1] = mkVec(0, 1, 4, 32'hDEAD, 5, 1, 0, 0, 0, 0, 1);
    vecs[2] = mkVec(1, 0, 4, 0, 7, 1, 32'hDEAD, 1, 0, 1, 0);
    vecs[3] = mkVec(0, 0, 8, 32'hCAFE_F00D, 9, 1, 32'hCAFE_F00D, 1, 0, 0, 0);
    vecs[4] = mkVec(0, 0, 0, 32'h55, 0, 0, 32'h55, 0, 0, 0, 0);
    vecs[5] = mkVec(1, 1, 2, 32'h777, 11, 1, 0, 0, 0, 0, 1);
    vecs[6] = mkVec(1, 0, 2, 0, 12, 1, 32'h777, 1, 0, 1, 0);
    vecs[7] = mkVec(1, 0, 9, 0, 13, 1, 32'h1009, 1, 0, 1, 0);
`ifdef MEM_BOUNDS_CHECK_EN
    vecs[8] = mkVec(1, 0, 12, 0, 14, 1, 0, 0, 1, 0, 0);
    vecs[9] = mkVec(0, 1, 10, 32'hABC, 15, 1, 0, 0, 1, 0, 0);
`else
    vecs[8] = mkVec(1, 0, 12, 0, 14, 1, 32'h100C, 1, 0, 1, 0);
    vecs[9] = mkVec(0, 1, 10, 32'hABC, 15, 1, 0, 0, 0, 0, 1);
`endif
    vecs[10] = mkVec(1, 0, 3, 0, 16, 0, 32'h1003, 0, 0, 1, 0);

    rstN = 1'b0; rstN3 = 1'b0; outReady = 1'b1;
    inValid = 1'b1; inRead = 1'b1; inWrite = 1'b0; inAddr = 32'd1;
    inWdata = 32'h0; inRd = 5'd3; inRegWrite = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_out_valid", outValid, 0);
    checkVal("reset_out_data", outData, 0);
    checkVal("reset_out_rd", outRd, 0);
    checkVal("reset_out_reg_write", outRegWrite, 0);
    checkVal("reset_out_err", outErr, 0);
    checkVal("reset_mem_read", memRead, 0);
    checkVal("reset_mem_write", memWrite, 0);
    checkVal("reset_mem_addr", memAddr, 0);
    checkVal("reset_mem_wdata", memWdata, 0);
    @(negedge clk);
    rstN = 1'b1;
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkVal("post_reset_in_ready", inReady, 1);
    checkVal("post_reset_out_valid", outValid, 0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(0);
    end

    // Backpressure: hold out_ready low for five RESP cycles on a load.
    outReady = 1'b0;
    applyStimulus(mkVec(1, 0, 1, 0, 3, 1, 32'd122, 1, 0, 1, 0));
    checkOutput(5);

    // WAIT_STATES=3 instance: store aborted by reset in its second WAIT cycle.
    @(negedge clk);
    rstN3 = 1'b1;
    @(negedge clk);
    checkVal("ws3_in_ready", inReady3, 1);
    inValid = 1'b1; inRead = 1'b0; inWrite = 1'b1; inAddr = 32'd3;
    inWdata = 32'hBEEF; inRd = 5'd4; inRegWrite = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkVal("ws3_wait1_no_write", memWrite3, 0);
    @(posedge clk);
    #1;
    rstN3 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkVal("ws3_abort_no_write", memWrite3, 0);
      checkVal("ws3_abort_no_valid", outValid3, 0);
    end
    rstN3 = 1'b1;

    // Same instance: load latency and read-strobe length with three wait states.
    @(negedge clk);
    checkVal("ws3_ready_after_abort", inReady3, 1);
    inValid = 1'b1; inRead = 1'b1; inWrite = 1'b0; inAddr = 32'd5;
    inWdata = 32'h0; inRd = 5'd6; inRegWrite = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    lat = 0;
    rc = 0;
    while (!outValid3 && lat < 50) begin
      if (memRead3) rc++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal("ws3_latency", lat, WS3);
    checkVal("ws3_read_cycles", rc, WS3);
    checkVal("ws3_out_data", outData3, 32'h1234_5678);
    checkVal("ws3_out_rd", outRd3, 6);
    checkVal("ws3_out_reg_write", outRegWrite3, 1);
    checkVal("ws3_out_err", outErr3, 0);
    checkVal("ws3_mem_read_off", memRead3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
